alu_uart_ctrl: RTL
==================

ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, width of UART bytes, ALU operands and ALU result.
REQ-002 The block SHALL have parameter OP_BITS, default 6, width of the ALU opcode; OP_BITS SHALL be <= DATA_BITS.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, inter-byte timeout in i_clock cycles; it is used only when RX_TIMEOUT_EN is defined.
REQ-004 The block SHALL have port i_clock, input, 1, system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port i_rx_data, input, DATA_BITS, received byte from the UART receiver; valid while i_rx_done=1.
REQ-007 The block SHALL have port i_rx_done, input, 1, one-cycle pulse marking a received byte.
REQ-008 The block SHALL have port i_tx_done, input, 1, one-cycle pulse marking completion of a UART transmission.
REQ-009 The block SHALL have port i_alu_result, input, DATA_BITS, combinational ALU result.
REQ-010 The block SHALL have ports o_alu_a and o_alu_b, output, DATA_BITS each, registered ALU operands.
REQ-011 The block SHALL have port o_alu_op, output, OP_BITS, registered ALU opcode.
REQ-012 The block SHALL have port o_tx_data, output, DATA_BITS, registered byte to transmit.
REQ-013 The block SHALL have port o_tx_start, output, 1, one-cycle transmit request.
REQ-014 The block SHALL have port o_busy, output, 1, high whenever the FSM is not in IDLE.
REQ-015 The block SHALL have port o_timeout, output, 1, one-cycle pulse on inter-byte timeout.

Function
REQ-016 The FSM SHALL have states IDLE, GET_B, GET_OP, EXEC, SEND and WAIT_TX, in that sequence.
REQ-017 In IDLE, i_rx_done=1 SHALL latch i_rx_data into o_alu_a and move to GET_B.
REQ-018 In GET_B, i_rx_done=1 SHALL latch i_rx_data into o_alu_b and move to GET_OP.
REQ-019 In GET_OP, i_rx_done=1 SHALL latch i_rx_data[OP_BITS-1:0] into o_alu_op, discard the upper bits, and move to EXEC.
REQ-020 EXEC SHALL last exactly one cycle, latch i_alu_result into o_tx_data and move to SEND.
REQ-021 SHALL hold o_tx_start high only in SEND, which lasts exactly one cycle and moves to WAIT_TX.
REQ-022 Latency: o_tx_start SHALL be high in the second cycle after the edge that samples the opcode byte's i_rx_done.
REQ-023 WAIT_TX SHALL stay until i_tx_done=1, then move to IDLE on that edge.
REQ-024 i_rx_done during EXEC, SEND or WAIT_TX SHALL be ignored; the byte is dropped and the registers are unchanged.
REQ-025 i_tx_done outside WAIT_TX SHALL be ignored.
REQ-026 o_alu_a, o_alu_b, o_alu_op and o_tx_data SHALL hold their last latched values in all other states and across transactions.

Reset
REQ-027 i_reset=1 SHALL force state IDLE and set o_alu_a, o_alu_b, o_alu_op, o_tx_data and the timeout counter to 0, asynchronously.
REQ-028 During and after reset, o_tx_start, o_busy and o_timeout SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL discard the partial frame; the first i_rx_done after reset is operand A.

Configuration
REQ-030 With macro RX_TIMEOUT_EN defined, a counter SHALL run in GET_B and GET_OP and clear to 0 on every accepted byte and on entry from IDLE.
REQ-031 With RX_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 with no i_rx_done in that cycle, the FSM SHALL return to IDLE, keep o_alu_a/o_alu_b/o_alu_op unchanged, and pulse o_timeout for one cycle.
REQ-032 With RX_TIMEOUT_EN defined, i_rx_done in the expiry cycle SHALL win: the byte is accepted and no timeout occurs.
REQ-033 Without RX_TIMEOUT_EN, the block SHALL contain no counter, SHALL tie o_timeout to 0, and GET_B/GET_OP SHALL wait indefinitely.

Verification
REQ-034 Bytes 8'h05, 8'h03, 8'h20 with i_alu_result=8'h08 -> o_alu_a=05, o_alu_b=03, o_alu_op=6'h20, o_tx_data=08, o_tx_start one pulse 2 cycles after the third i_rx_done.
REQ-035 Opcode byte 8'hE2 (OP_BITS=6) -> o_alu_op=6'h22.
REQ-036 Extra byte 8'hAA in WAIT_TX, then i_tx_done -> registers unchanged, IDLE, o_busy=0; the next byte becomes o_alu_a.
REQ-037 i_reset asserted in GET_OP after bytes 11, 22 -> all outputs 0 immediately; a new 3-byte frame completes normally.
REQ-038 RX_TIMEOUT_EN, TIMEOUT_CYCLES=16: one byte then silence -> o_timeout pulse 16 cycles after the GET_B entry, IDLE; a byte arriving at cycle 15 -> accepted, no timeout.
REQ-039 Without RX_TIMEOUT_EN: one byte then 10000 idle cycles -> still GET_B, o_timeout=0.

Source files
------------

// File: rtl/alu_uart_ctrl.sv
// Collects operand A, operand B and an opcode byte from a UART receiver, then
// sends the ALU result back. Optional inter-byte timeout: define RX_TIMEOUT_EN.
module alu_uart_ctrl #(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned OP_BITS        = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_tx_done,
  input  logic [DATA_BITS-1:0] i_alu_result,
  output logic [DATA_BITS-1:0] o_alu_a,
  output logic [DATA_BITS-1:0] o_alu_b,
  output logic [OP_BITS-1:0]   o_alu_op,
  output logic [DATA_BITS-1:0] o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy,
  output logic                 o_timeout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t               state, state_nx;
  logic [DATA_BITS-1:0] alu_a_nx, alu_b_nx, tx_data_nx;
  logic [OP_BITS-1:0]   alu_op_nx;
  logic                 tx_start_nx, busy_nx;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned CNT_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

  logic [CNT_BITS-1:0] cnt, cnt_nx;
  logic                timeout_nx;
  logic                expired;

  assign expired = (cnt == CNT_LAST);
`endif

  // Next-state and next register values; outputs are registered from these.
  always_comb begin
    state_nx   = state;
    alu_a_nx   = o_alu_a;
    alu_b_nx   = o_alu_b;
    alu_op_nx  = o_alu_op;
    tx_data_nx = o_tx_data;
`ifdef RX_TIMEOUT_EN
    cnt_nx     = '0;
    timeout_nx = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (i_rx_done) begin
          alu_a_nx = i_rx_data;
          state_nx = GET_B;
        end
      end
      GET_B: begin
        if (i_rx_done) begin
          alu_b_nx = i_rx_data;
          state_nx = GET_OP;
        end
`ifdef RX_TIMEOUT_EN
        else if (expired) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_BITS'(1);
        end
`endif
      end
      GET_OP: begin
        if (i_rx_done) begin
          alu_op_nx = i_rx_data[OP_BITS-1:0];
          state_nx  = EXEC;
        end
`ifdef RX_TIMEOUT_EN
        else if (expired) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_BITS'(1);
        end
`endif
      end
      EXEC: begin
        tx_data_nx = i_alu_result;
        state_nx   = SEND;
      end
      SEND: begin
        state_nx = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    tx_start_nx = (state_nx == SEND);
    busy_nx     = (state_nx != IDLE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_nx;
      o_alu_a    <= alu_a_nx;
      o_alu_b    <= alu_b_nx;
      o_alu_op   <= alu_op_nx;
      o_tx_data  <= tx_data_nx;
      o_tx_start <= tx_start_nx;
      o_busy     <= busy_nx;
    end
  end

`ifdef RX_TIMEOUT_EN
  // Inter-byte counter and its one-cycle expiry pulse.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt       <= '0;
      o_timeout <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      o_timeout <= timeout_nx;
    end
  end
`else
  assign o_timeout = 1'b0;
`endif

endmodule
